// File: rtl/hack_exec_ctrl.sv
// Multi-cycle Hack CPU sequencer: fetch, decode, optional M read, ALU execute,
// optional M write and conditional jump, with req/ack handshakes on both memories.
module hack_exec_ctrl #(
    parameter int              PC_W     = 15,
    parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}}
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            run,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [15:0]     imem_data,
    output logic            dmem_rd,
    output logic            dmem_wr,
    output logic [PC_W-1:0] dmem_addr,
    output logic [15:0]     dmem_wdata,
    input  logic            dmem_ack,
    input  logic [15:0]     dmem_rdata,
    output logic [15:0]     alu_x,
    output logic [15:0]     alu_y,
    output logic [5:0]      alu_fn,
    input  logic [15:0]     alu_out,
    input  logic            alu_zero,
    output logic [PC_W-1:0] pc,
    output logic [15:0]     a_reg,
    output logic [15:0]     d_reg,
    output logic            retire
);

    localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_MREAD  = 3'd2,
        S_EXEC   = 3'd3,
        S_MWRITE = 3'd4
    } state_e;

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] addr_q, addr_d;
    logic [15:0]     a_q, a_d;
    logic [15:0]     d_q, d_d;
    logic [15:0]     ir_q, ir_d;
    logic [15:0]     m_q, m_d;
    logic [15:0]     wdata_q, wdata_d;
    logic [5:0]      fn_q, fn_d;
    logic            neg_q, neg_d;
    logic            zero_q, zero_d;
    logic            imem_req_q, imem_req_d;
    logic            dmem_rd_q, dmem_rd_d;
    logic            dmem_wr_q, dmem_wr_d;
    logic            retire_q, retire_d;

    logic            res_neg_s;
    logic            res_zero_s;
    logic            jump_s;
    logic [PC_W-1:0] next_pc_s;

    // addr_q holds A at instruction start: it is both the M address and the jump target
    always_comb begin
        res_neg_s  = (state_q == S_EXEC) ? alu_out[15] : neg_q;
        res_zero_s = (state_q == S_EXEC) ? alu_zero    : zero_q;
        jump_s     = (ir_q[2] & res_neg_s) | (ir_q[1] & res_zero_s) |
                     (ir_q[0] & ~res_neg_s & ~res_zero_s);
        next_pc_s  = jump_s ? addr_q : (pc_q + PC_ONE);
    end

    // Next-state and datapath update for the instruction sequencer
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        addr_d     = addr_q;
        a_d        = a_q;
        d_d        = d_q;
        ir_d       = ir_q;
        m_d        = m_q;
        wdata_d    = wdata_q;
        fn_d       = fn_q;
        neg_d      = neg_q;
        zero_d     = zero_q;
        imem_req_d = 1'b0;
        dmem_rd_d  = 1'b0;
        dmem_wr_d  = 1'b0;
        retire_d   = 1'b0;

        case (state_q)
            S_FETCH: begin
                if (imem_req_q) begin
                    if (imem_ack) begin
                        ir_d    = imem_data;
                        state_d = S_DECODE;
                    end else begin
                        imem_req_d = 1'b1;
                    end
                end else begin
                    imem_req_d = run;
                end
            end
            S_DECODE: begin
                addr_d = a_q[PC_W-1:0];
                if (!ir_q[15]) begin
                    a_d        = ir_q;
                    pc_d       = pc_q + PC_ONE;
                    retire_d   = 1'b1;
                    imem_req_d = run;
                    state_d    = S_FETCH;
                end else begin
                    fn_d = ir_q[11:6];
                    if (ir_q[12]) begin
                        dmem_rd_d = 1'b1;
                        state_d   = S_MREAD;
                    end else begin
                        state_d = S_EXEC;
                    end
                end
            end
            S_MREAD: begin
                if (dmem_ack) begin
                    m_d     = dmem_rdata;
                    state_d = S_EXEC;
                end else begin
                    dmem_rd_d = 1'b1;
                end
            end
            S_EXEC: begin
                if (ir_q[5]) begin
                    a_d = alu_out;
                end else begin
                    a_d = a_q;
                end
                if (ir_q[4]) begin
                    d_d = alu_out;
                end else begin
                    d_d = d_q;
                end
                neg_d  = alu_out[15];
                zero_d = alu_zero;
                if (ir_q[3]) begin
                    wdata_d   = alu_out;
                    dmem_wr_d = 1'b1;
                    state_d   = S_MWRITE;
                end else begin
                    pc_d       = next_pc_s;
                    retire_d   = 1'b1;
                    imem_req_d = run;
                    state_d    = S_FETCH;
                end
            end
            S_MWRITE: begin
                if (dmem_ack) begin
                    pc_d       = next_pc_s;
                    retire_d   = 1'b1;
                    imem_req_d = run;
                    state_d    = S_FETCH;
                end else begin
                    dmem_wr_d = 1'b1;
                end
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // State and output registers; reset overrides any pending handshake
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_FETCH;
            pc_q       <= RESET_PC;
            addr_q     <= {PC_W{1'b0}};
            a_q        <= 16'h0000;
            d_q        <= 16'h0000;
            ir_q       <= 16'h0000;
            m_q        <= 16'h0000;
            wdata_q    <= 16'h0000;
            fn_q       <= 6'b000000;
            neg_q      <= 1'b0;
            zero_q     <= 1'b0;
            imem_req_q <= 1'b0;
            dmem_rd_q  <= 1'b0;
            dmem_wr_q  <= 1'b0;
            retire_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            addr_q     <= addr_d;
            a_q        <= a_d;
            d_q        <= d_d;
            ir_q       <= ir_d;
            m_q        <= m_d;
            wdata_q    <= wdata_d;
            fn_q       <= fn_d;
            neg_q      <= neg_d;
            zero_q     <= zero_d;
            imem_req_q <= imem_req_d;
            dmem_rd_q  <= dmem_rd_d;
            dmem_wr_q  <= dmem_wr_d;
            retire_q   <= retire_d;
        end
    end

    assign imem_req   = imem_req_q;
    assign imem_addr  = pc_q;
    assign dmem_rd    = dmem_rd_q;
    assign dmem_wr    = dmem_wr_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;
    assign alu_x      = d_q;
    assign alu_y      = ir_q[12] ? m_q : a_q;
    assign alu_fn     = fn_q;
    assign pc         = pc_q;
    assign a_reg      = a_q;
    assign d_reg      = d_q;
    assign retire     = retire_q;

endmodule

// File: tb/tb_hack_exec_ctrl.sv
// Bench for hack_exec_ctrl: memory responders with programmable ack latency, a Hack ALU,
// a directed instruction table and a random program checked against an ISA-level model.
module tb_hack_exec_ctrl;

    logic        clk = 1'b0;
    logic        reset, run;
    logic        imem_req, imem_ack;
    logic [14:0] imem_addr;
    logic [15:0] imem_data;
    logic        dmem_rd, dmem_wr, dmem_ack;
    logic [14:0] dmem_addr;
    logic [15:0] dmem_wdata, dmem_rdata;
    logic [15:0] alu_x, alu_y, alu_out;
    logic [5:0]  alu_fn;
    logic        alu_zero;
    logic [14:0] pc;
    logic [15:0] a_reg, d_reg;
    logic        retire;

    hack_exec_ctrl #(.PC_W(15), .RESET_PC(15'h0000)) dut (
        .clk(clk), .reset(reset), .run(run),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
        .dmem_rd(dmem_rd), .dmem_wr(dmem_wr), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .alu_x(alu_x), .alu_y(alu_y), .alu_fn(alu_fn), .alu_out(alu_out), .alu_zero(alu_zero),
        .pc(pc), .a_reg(a_reg), .d_reg(d_reg), .retire(retire)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] hack_alu(input logic [15:0] x, input logic [15:0] y,
                                             input logic [5:0] fn);
        logic [15:0] xx, yy, o;
        xx = fn[5] ? 16'h0000 : x;
        xx = fn[4] ? ~xx : xx;
        yy = fn[3] ? 16'h0000 : y;
        yy = fn[2] ? ~yy : yy;
        o  = fn[1] ? (xx + yy) : (xx & yy);
        return fn[0] ? ~o : o;
    endfunction

    always_comb begin
        alu_out  = hack_alu(alu_x, alu_y, alu_fn);
        alu_zero = (alu_out == 16'h0000);
    end

    logic [15:0] imem    [32768];
    logic [15:0] dmem    [32768];
    logic [15:0] ref_mem [32768];

    int total = 0, bad = 0;
    int retire_cnt = 0, wr_count = 0, rd_count = 0;
    int i_wait = 0, d_wait = 0, i_lat = 0, d_lat = 0;
    bit i_busy = 1'b0, d_busy = 1'b0, d_is_wr = 1'b0;
    logic [14:0] d_addr_l, last_rd_addr, last_wr_addr;
    logic [15:0] d_wdata_l, last_wr_data;
    logic [5:0]  cur_fn, prev_fn;
    logic [15:0] cur_y, prev_y;

    logic [14:0] m_pc;
    logic [15:0] m_a, m_d;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", nm, act, exp);
        end
    endtask

    // One clock: drive responder inputs, take the edge, then observe outputs
    task automatic cycle();
        if (imem_req && !i_busy) begin
            i_busy = 1'b1;
            i_wait = i_lat;
        end
        if (i_busy && i_wait == 0) begin
            imem_ack  = 1'b1;
            imem_data = imem[imem_addr];
        end else begin
            imem_ack = 1'b0;
            if (i_busy) i_wait--;
        end
        if ((dmem_rd || dmem_wr) && !d_busy) begin
            d_busy    = 1'b1;
            d_wait    = d_lat;
            d_is_wr   = dmem_wr;
            d_addr_l  = dmem_addr;
            d_wdata_l = dmem_wdata;
            if (dmem_rd) begin
                rd_count++;
                last_rd_addr = dmem_addr;
            end
        end
        if (d_busy && d_wait == 0) begin
            dmem_ack   = 1'b1;
            dmem_rdata = dmem[d_addr_l];
        end else begin
            dmem_ack = 1'b0;
            if (d_busy) d_wait--;
        end
        @(posedge clk);
        #1;
        if (reset) begin
            i_busy = 1'b0;
            d_busy = 1'b0;
        end else begin
            if (imem_ack) i_busy = 1'b0;
            if (dmem_ack) begin
                d_busy = 1'b0;
                if (d_is_wr) begin
                    dmem[d_addr_l] = d_wdata_l;
                    wr_count++;
                    last_wr_addr = d_addr_l;
                    last_wr_data = d_wdata_l;
                end
            end
        end
        prev_fn = cur_fn;
        prev_y  = cur_y;
        cur_fn  = alu_fn;
        cur_y   = alu_y;
        if (retire) retire_cnt++;
        total++;
        if ((dmem_rd && dmem_wr) || (imem_req && (dmem_rd || dmem_wr))) begin
            bad++;
            $display("FAIL strobe_exclusive: imem_req=%b rd=%b wr=%b", imem_req, dmem_rd, dmem_wr);
        end
    endtask

    task automatic wait_retire(output int n);
        n = 0;
        do begin
            cycle();
            n++;
        end while (!retire && n < 100);
        chk("retire_seen", {31'd0, retire}, 32'd1);
    endtask

    // ISA-level reference: executes one instruction on the model state
    task automatic ref_step(input logic [15:0] ins);
        logic [15:0] y, o, old_a;
        logic lt, eq, gt, jmp;
        if (!ins[15]) begin
            m_a  = ins;
            m_pc = m_pc + 15'd1;
        end else begin
            old_a = m_a;
            y = ins[12] ? ref_mem[old_a[14:0]] : old_a;
            o = hack_alu(m_d, y, ins[11:6]);
            if (ins[3]) ref_mem[old_a[14:0]] = o;
            if (ins[5]) m_a = o;
            if (ins[4]) m_d = o;
            lt  = ($signed(o) < 0);
            eq  = (o == 16'h0000);
            gt  = !lt && !eq;
            jmp = (ins[2] && lt) || (ins[1] && eq) || (ins[0] && gt);
            m_pc = jmp ? old_a[14:0] : (m_pc + 15'd1);
        end
    endtask

    function automatic logic [15:0] rand_instr();
        logic [31:0] v;
        v = $urandom;
        if (v[31:29] < 3'd3) return {1'b0, v[14:0]};
        return {3'b111, v[12:0]};
    endfunction

    typedef struct {
        logic [15:0] instr;
        int          dlat;
        logic [15:0] minit;
        logic [15:0] ea;
        logic [15:0] ed;
        logic [14:0] epc;
        bit          erd;
        bit          ewr;
        logic [15:0] ewd;
        int          ecyc;
        bit          calu;
        logic [5:0]  efn;
        logic [15:0] ey;
    } vec_t;

    vec_t vt [18];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, rc0, wc0;
        logic [15:0] cur_a, ins, old_a;
        logic [14:0] pc_track;

        vt[0]  = '{16'h0005, 0, 16'h0000, 16'h0005, 16'h0000, 15'h0001, 1'b0, 1'b0, 16'h0000, 0, 1'b0, 6'b000000, 16'h0000};
        vt[1]  = '{16'hEC10, 0, 16'h0000, 16'h0005, 16'h0005, 15'h0002, 1'b0, 1'b0, 16'h0000, 3, 1'b1, 6'b110000, 16'h0005};
        vt[2]  = '{16'h0003, 0, 16'h0000, 16'h0003, 16'h0005, 15'h0003, 1'b0, 1'b0, 16'h0000, 2, 1'b0, 6'b000000, 16'h0000};
        vt[3]  = '{16'hEC10, 0, 16'h0000, 16'h0003, 16'h0003, 15'h0004, 1'b0, 1'b0, 16'h0000, 3, 1'b0, 6'b000000, 16'h0000};
        vt[4]  = '{16'h0007, 0, 16'h0000, 16'h0007, 16'h0003, 15'h0005, 1'b0, 1'b0, 16'h0000, 2, 1'b0, 6'b000000, 16'h0000};
        vt[5]  = '{16'hFDC8, 3, 16'h0041, 16'h0007, 16'h0003, 15'h0006, 1'b1, 1'b1, 16'h0042, 0, 1'b0, 6'b000000, 16'h0000};
        vt[6]  = '{16'h0010, 0, 16'h0000, 16'h0010, 16'h0003, 15'h0007, 1'b0, 1'b0, 16'h0000, 2, 1'b0, 6'b000000, 16'h0000};
        vt[7]  = '{16'hEFD0, 0, 16'h0000, 16'h0010, 16'h0001, 15'h0008, 1'b0, 1'b0, 16'h0000, 3, 1'b1, 6'b111111, 16'h0010};
        vt[8]  = '{16'hE301, 0, 16'h0000, 16'h0010, 16'h0001, 15'h0010, 1'b0, 1'b0, 16'h0000, 3, 1'b0, 6'b000000, 16'h0000};
        vt[9]  = '{16'hEA90, 0, 16'h0000, 16'h0010, 16'h0000, 15'h0011, 1'b0, 1'b0, 16'h0000, 3, 1'b0, 6'b000000, 16'h0000};
        vt[10] = '{16'hE301, 0, 16'h0000, 16'h0010, 16'h0000, 15'h0012, 1'b0, 1'b0, 16'h0000, 3, 1'b0, 6'b000000, 16'h0000};
        vt[11] = '{16'hEE90, 0, 16'h0000, 16'h0010, 16'hFFFF, 15'h0013, 1'b0, 1'b0, 16'h0000, 3, 1'b0, 6'b000000, 16'h0000};
        vt[12] = '{16'hE304, 0, 16'h0000, 16'h0010, 16'hFFFF, 15'h0010, 1'b0, 1'b0, 16'h0000, 3, 1'b0, 6'b000000, 16'h0000};
        vt[13] = '{16'h0009, 0, 16'h0000, 16'h0009, 16'hFFFF, 15'h0011, 1'b0, 1'b0, 16'h0000, 2, 1'b0, 6'b000000, 16'h0000};
        vt[14] = '{16'hEDEF, 0, 16'h0000, 16'h000A, 16'hFFFF, 15'h0009, 1'b0, 1'b1, 16'h000A, 4, 1'b0, 6'b000000, 16'h0000};
        vt[15] = '{16'h7FFF, 0, 16'h0000, 16'h7FFF, 16'hFFFF, 15'h000A, 1'b0, 1'b0, 16'h0000, 2, 1'b0, 6'b000000, 16'h0000};
        vt[16] = '{16'hEA87, 0, 16'h0000, 16'h7FFF, 16'hFFFF, 15'h7FFF, 1'b0, 1'b0, 16'h0000, 3, 1'b0, 6'b000000, 16'h0000};
        vt[17] = '{16'h0123, 0, 16'h0000, 16'h0123, 16'hFFFF, 15'h0000, 1'b0, 1'b0, 16'h0000, 2, 1'b0, 6'b000000, 16'h0000};

        reset = 1'b1; run = 1'b0;
        imem_ack = 1'b0; dmem_ack = 1'b0;
        imem_data = 16'h0000; dmem_rdata = 16'h0000;
        for (int k = 0; k < 32768; k++) begin
            imem[k] = 16'h0000;
            dmem[k] = 16'h0000;
        end
        cycle();
        cycle();
        chk("rst_pc", {17'd0, pc}, 32'd0);
        chk("rst_a", {16'd0, a_reg}, 32'd0);
        chk("rst_d", {16'd0, d_reg}, 32'd0);
        chk("rst_strobes", {28'd0, imem_req, dmem_rd, dmem_wr, retire}, 32'd0);
        chk("rst_alu_fn", {26'd0, alu_fn}, 32'd0);
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cycle();
            chk("parked_no_req", {31'd0, imem_req}, 32'd0);
        end
        run = 1'b1;
        retire_cnt = 0;

        cur_a = 16'h0000;
        pc_track = 15'h0000;
        for (int i = 0; i < 18; i++) begin
            imem[pc_track] = vt[i].instr;
            dmem[cur_a[14:0]] = vt[i].minit;
            d_lat = vt[i].dlat;
            rc0 = rd_count;
            wc0 = wr_count;
            wait_retire(n);
            chk($sformatf("pc[%0d]", i), {17'd0, pc}, {17'd0, vt[i].epc});
            chk($sformatf("a[%0d]", i), {16'd0, a_reg}, {16'd0, vt[i].ea});
            chk($sformatf("d[%0d]", i), {16'd0, d_reg}, {16'd0, vt[i].ed});
            chk($sformatf("reads[%0d]", i), rd_count - rc0, {31'd0, vt[i].erd});
            chk($sformatf("writes[%0d]", i), wr_count - wc0, {31'd0, vt[i].ewr});
            if (vt[i].erd) chk($sformatf("rd_addr[%0d]", i), {17'd0, last_rd_addr}, {17'd0, cur_a[14:0]});
            if (vt[i].ewr) begin
                chk($sformatf("wr_addr[%0d]", i), {17'd0, last_wr_addr}, {17'd0, cur_a[14:0]});
                chk($sformatf("wr_data[%0d]", i), {16'd0, last_wr_data}, {16'd0, vt[i].ewd});
            end
            if (vt[i].ecyc != 0) chk($sformatf("cycles[%0d]", i), n, vt[i].ecyc);
            if (vt[i].calu) begin
                chk($sformatf("alu_fn[%0d]", i), {26'd0, prev_fn}, {26'd0, vt[i].efn});
                chk($sformatf("alu_y[%0d]", i), {16'd0, prev_y}, {16'd0, vt[i].ey});
            end
            cur_a = vt[i].ea;
            pc_track = vt[i].epc;
        end
        chk("retire_count", retire_cnt, 32'd18);

        // Reset lands while a fetch is still waiting for its ack
        i_lat = 6;
        cycle();
        cycle();
        chk("req_pending", {31'd0, imem_req}, 32'd1);
        reset = 1'b1;
        cycle();
        chk("rst_req_low", {31'd0, imem_req}, 32'd0);
        chk("rst_pc_again", {17'd0, pc}, 32'd0);
        chk("rst_retire_low", {31'd0, retire}, 32'd0);

        for (int k = 0; k < 32768; k++) begin
            logic [31:0] v;
            imem[k] = rand_instr();
            v = $urandom;
            dmem[k] = v[15:0];
            ref_mem[k] = v[15:0];
        end
        m_pc = 15'h0000; m_a = 16'h0000; m_d = 16'h0000;
        cycle();
        reset = 1'b0;
        for (int it = 0; it < 300; it++) begin
            i_lat = $urandom_range(0, 2);
            d_lat = $urandom_range(0, 3);
            ins = imem[m_pc];
            old_a = m_a;
            wait_retire(n);
            ref_step(ins);
            chk($sformatf("rnd_pc[%0d]", it), {17'd0, pc}, {17'd0, m_pc});
            chk($sformatf("rnd_a[%0d]", it), {16'd0, a_reg}, {16'd0, m_a});
            chk($sformatf("rnd_d[%0d]", it), {16'd0, d_reg}, {16'd0, m_d});
            if (ins[15] && ins[3])
                chk($sformatf("rnd_mem[%0d]", it), {16'd0, dmem[old_a[14:0]]}, {16'd0, ref_mem[old_a[14:0]]});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
